ext_mem_loader: RTL and testbench
=================================

# ext_mem_loader

Host-side initiator for the CPU's external memory ports. It streams a program into instruction memory over the `*_ext` port and runs the CPU for a programmed number of cycles by holding `enable`. It then reads a window of data memory over the `*_ext_2` port and streams the words out. It sits beside `cpu` in the top level and is the only driver of the CPU's external load/dump ports and `enable`.

## Interface
- `IMEM_WORDS`, default 512: instruction memory depth in 32-bit words; load counts are clamped to this value.
- `DMEM_WORDS`, default 1024: data memory depth in 64-bit words; dump counts are clamped to this value.
- `clk` input 1: clock.
- `arst_n` input 1: reset, synchronous active-low.
- `start` input 1: one-cycle request; sampled only in IDLE.
- `imem_count` input 10: number of words to load; latched on start.
- `run_cycles` input 32: number of CPU enable cycles; latched on start.
- `dump_count` input 11: number of data words to dump; latched on start.
- `s_valid` input 1, `s_ready` output 1, `s_data` input 32: program word stream.
- `m_valid` output 1, `m_ready` input 1, `m_data` output 64, `m_last` output 1: dump stream.
- `busy` output 1: high from the cycle after an accepted start until done.
- `done` output 1: one-cycle pulse at completion.
- `cpu_enable` output 1: drives `cpu.enable`.
- `addr_ext` output 64, `wen_ext` output 1, `wdata_ext` output 32: instruction memory write port.
- `addr_ext_2` output 64, `ren_ext_2` output 1: data memory read port.
- `rdata_ext_2` input 64: data memory read data.

## Operation
- FSM states: IDLE, LOAD, RUN, RD_REQ, RD_WAIT, OUT, DONE.
- IDLE:
  - All outputs are 0.
  - When `start`=1, latch the counts and clear the word and cycle counters, then go to LOAD.
  - LOAD is skipped to RUN if the clamped `imem_count`=0.
  - `start` is ignored in any other state.
- LOAD:
  - `s_ready`=1 while `load_idx < imem_count`.
  - Each handshake registers a write in the next cycle: `wen_ext`=1, `addr_ext`=`load_idx`*4 (byte address, zero-extended), `wdata_ext`=`s_data`.
  - After the final word's write cycle, go to RUN.
  - `s_ready` drops in the cycle after the last accept.
- RUN:
  - `cpu_enable`=1 for exactly `run_cycles` consecutive cycles, then 0.
  - `run_cycles`=0 passes through to RD_REQ with `cpu_enable` never asserted.
  - If `dump_count`=0, go straight to DONE.
- RD_REQ: `ren_ext_2`=1 for one cycle with `addr_ext_2`=`dump_idx`*8.
- RD_WAIT: data memory has 1-cycle read latency. Capture `rdata_ext_2` into the `m_data` register at the end of this cycle.
- OUT:
  - `m_valid`=1; `m_last`=1 when `dump_idx`==`dump_count`-1.
  - `m_data` and `m_last` are held stable until `m_ready`.
  - On handshake, increment `dump_idx`. Go to RD_REQ, or to DONE after the last word.
- DONE: `done`=1 and `busy`=0 for one cycle, then IDLE.
- Counters are width-exact with no wrap: `load_idx` is 10 bits, `dump_idx` is 11 bits, the run counter is 32 bits. Clamping guarantees the indices never exceed depth-1.
- `wen_ext` and `ren_ext_2` are never asserted in the same cycle, and neither is asserted while `cpu_enable`=1.

## Timing
- All outputs are registered. On reset every output is 0 and the state is IDLE.
- `start` in cycle 0 → `busy`=1 in cycle 1; `s_ready` can be 1 in cycle 1.
- LOAD: accept in cycle k → write in cycle k+1. Throughput is 1 word per cycle under a continuous `s_valid`.
- Dump: 3 cycles per word (RD_REQ, RD_WAIT, OUT) when `m_ready` is held at 1.
- `s_valid` dropping mid-load stalls LOAD indefinitely. There is no timeout.
- `m_ready` low stalls OUT; no further read is issued until the current word is accepted.
- Reset asserted in any state:
  - next edge: state IDLE, all outputs 0, partial load or dump abandoned;
  - memory contents already written are left as is.

## Structure
- Package `ext_loader_pkg` holds:
  - the state enum;
  - `IMEM_BYTE_STRIDE`=4 and `DMEM_BYTE_STRIDE`=8;
  - the count widths.
- Single flat module; no sub-module is warranted.
- Top-level integration ties `cpu.wen_ext_2`=0, `cpu.wdata_ext_2`=0 and `cpu.ren_ext`=0.

## Test plan
- `imem_count`=3, stream 0x00500093/0x00A00113/0x002081B3 with no gaps → `wen_ext` pulses in cycles 2,3,4 at `addr_ext` 0,4,8 with matching data.
- `run_cycles`=20 → `cpu_enable` high for exactly 20 cycles. `run_cycles`=0 → `cpu_enable` never high.
- Data memory preloaded with words 0..3 = 0x11..0x44, `dump_count`=4, `m_ready`=1 → `m_data` 0x11,0x22,0x33,0x44 at 3-cycle spacing; `m_last` only on 0x44; `done` one cycle after.
- `m_ready` held low for 5 cycles on word 1 → `m_data` stable, no `ren_ext_2` until accepted.
- `arst_n` low during LOAD after 2 of 5 words → all outputs 0 next cycle. A new `start` performs a clean full load from address 0.
- `imem_count`=1023 with `IMEM_WORDS`=512 → exactly 512 writes, last at `addr_ext`=2044. `start` pulsed while busy → ignored.

Source files
------------

// File: rtl/ext_loader_pkg.sv
// Shared types and constants for the external memory loader.
package ext_loader_pkg;

  localparam int IMEM_CNT_W       = 10;
  localparam int DMEM_CNT_W       = 11;
  localparam int RUN_CNT_W        = 32;
  localparam int IMEM_BYTE_STRIDE = 4;
  localparam int DMEM_BYTE_STRIDE = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_RUN     = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_WAIT = 3'd4,
    ST_OUT     = 3'd5,
    ST_DONE    = 3'd6
  } loader_state_e;

endpackage

// File: rtl/ext_mem_loader.sv
// Host-side initiator: loads a program into instruction memory, runs the CPU
// for a fixed number of cycles, then streams a window of data memory out.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | all outputs low, waiting for start
// ST_LOAD    | accepting program words, one registered imem write each
// ST_RUN     | cpu_enable held high for the latched number of cycles
// ST_RD_REQ  | one-cycle data memory read request
// ST_RD_WAIT | read latency cycle, read data captured at its end
// ST_OUT     | word offered on the dump stream until accepted
// ST_DONE    | one-cycle completion pulse
module ext_mem_loader
  import ext_loader_pkg::*;
#(
  parameter int IMEM_WORDS = 512,
  parameter int DMEM_WORDS = 1024
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  start,
  input  logic [IMEM_CNT_W-1:0] imem_count,
  input  logic [RUN_CNT_W-1:0]  run_cycles,
  input  logic [DMEM_CNT_W-1:0] dump_count,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [31:0]           s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [63:0]           m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done,
  output logic                  cpu_enable,
  output logic [63:0]           addr_ext,
  output logic                  wen_ext,
  output logic [31:0]           wdata_ext,
  output logic [63:0]           addr_ext_2,
  output logic                  ren_ext_2,
  input  logic [63:0]           rdata_ext_2
);

  loader_state_e state_q, state_d;

  logic [IMEM_CNT_W-1:0] load_cnt_q, load_cnt_d;
  logic [IMEM_CNT_W-1:0] load_idx_q, load_idx_d;
  logic [DMEM_CNT_W-1:0] dump_cnt_q, dump_cnt_d;
  logic [DMEM_CNT_W-1:0] dump_idx_q, dump_idx_d;
  logic [RUN_CNT_W-1:0]  run_cnt_q, run_cnt_d;

  logic        s_ready_q, s_ready_d;
  logic        wen_q, wen_d;
  logic [63:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        ren_q, ren_d;
  logic [63:0] addr2_q, addr2_d;
  logic        m_valid_q, m_valid_d;
  logic [63:0] m_data_q, m_data_d;
  logic        m_last_q, m_last_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        cpu_en_q, cpu_en_d;

  logic [IMEM_CNT_W-1:0] imem_clamped;
  logic [DMEM_CNT_W-1:0] dump_clamped;
  logic                  s_hs;
  logic                  m_hs;

  assign imem_clamped = (32'(imem_count) > 32'(IMEM_WORDS)) ? IMEM_CNT_W'(IMEM_WORDS) : imem_count;
  assign dump_clamped = (32'(dump_count) > 32'(DMEM_WORDS)) ? DMEM_CNT_W'(DMEM_WORDS) : dump_count;

  assign s_hs = (state_q == ST_LOAD) && s_valid && s_ready_q;
  assign m_hs = (state_q == ST_OUT) && m_valid_q && m_ready;

  // State, counters and every output register; reset is synchronous.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_q    <= ST_IDLE;
      load_cnt_q <= '0;
      load_idx_q <= '0;
      dump_cnt_q <= '0;
      dump_idx_q <= '0;
      run_cnt_q  <= '0;
      s_ready_q  <= 1'b0;
      wen_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ren_q      <= 1'b0;
      addr2_q    <= '0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      m_last_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cpu_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      load_idx_q <= load_idx_d;
      dump_cnt_q <= dump_cnt_d;
      dump_idx_q <= dump_idx_d;
      run_cnt_q  <= run_cnt_d;
      s_ready_q  <= s_ready_d;
      wen_q      <= wen_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      ren_q      <= ren_d;
      addr2_q    <= addr2_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      m_last_q   <= m_last_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cpu_en_q   <= cpu_en_d;
    end
  end

  // Next state plus the word, dump and run counters.
  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    load_idx_d = load_idx_q;
    dump_cnt_d = dump_cnt_q;
    dump_idx_d = dump_idx_q;
    run_cnt_d  = run_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          load_cnt_d = imem_clamped;
          dump_cnt_d = dump_clamped;
          run_cnt_d  = run_cycles;
          load_idx_d = '0;
          dump_idx_d = '0;
          state_d    = (imem_clamped == '0) ? ST_RUN : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (s_hs) load_idx_d = load_idx_q + IMEM_CNT_W'(1);
        // All words accepted means this is the final write cycle.
        if (load_idx_q == load_cnt_q) state_d = ST_RUN;
      end
      ST_RUN: begin
        // run_cnt_q counts enabled cycles remaining, including this one.
        if (cpu_en_q) run_cnt_d = run_cnt_q - RUN_CNT_W'(1);
        if (!cpu_en_q || (run_cnt_q == RUN_CNT_W'(1)))
          state_d = (dump_cnt_q == '0) ? ST_DONE : ST_RD_REQ;
      end
      ST_RD_REQ:  state_d = ST_RD_WAIT;
      ST_RD_WAIT: state_d = ST_OUT;
      ST_OUT: begin
        if (m_hs) begin
          dump_idx_d = dump_idx_q + DMEM_CNT_W'(1);
          state_d    = (dump_idx_q == dump_cnt_q - DMEM_CNT_W'(1)) ? ST_DONE : ST_RD_REQ;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output values for the coming cycle, derived from the next state.
  always_comb begin
    s_ready_d = (state_d == ST_LOAD) && (load_idx_d < load_cnt_d);
    wen_d     = s_hs;
    addr_d    = s_hs ? 64'(load_idx_q) * 64'(IMEM_BYTE_STRIDE) : 64'd0;
    wdata_d   = s_hs ? s_data : 32'd0;
    cpu_en_d  = (state_d == ST_RUN) && (run_cnt_d != '0);
    ren_d     = (state_d == ST_RD_REQ);
    addr2_d   = ren_d ? 64'(dump_idx_d) * 64'(DMEM_BYTE_STRIDE) : 64'd0;
    m_valid_d = (state_d == ST_OUT);
    m_last_d  = (state_d == ST_OUT) && (dump_idx_d == dump_cnt_d - DMEM_CNT_W'(1));
    if (state_q == ST_RD_WAIT)   m_data_d = rdata_ext_2;
    else if (state_d == ST_OUT)  m_data_d = m_data_q;
    else                         m_data_d = 64'd0;
    busy_d    = (state_d != ST_IDLE) && (state_d != ST_DONE);
    done_d    = (state_d == ST_DONE);
  end

  assign s_ready    = s_ready_q;
  assign wen_ext    = wen_q;
  assign addr_ext   = addr_q;
  assign wdata_ext  = wdata_q;
  assign ren_ext_2  = ren_q;
  assign addr_ext_2 = addr2_q;
  assign m_valid    = m_valid_q;
  assign m_data     = m_data_q;
  assign m_last     = m_last_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign cpu_enable = cpu_en_q;

endmodule

// File: tb/tb_ext_mem_loader.sv
// Self-checking bench for ext_mem_loader: directed vector table, hand-written
// stall/reset sequences and randomized transactions against a behavioural model.
module tb_ext_mem_loader;

  localparam int IMEM_WORDS = 512;
  localparam int DMEM_WORDS = 1024;
  localparam logic [31:0] SENT = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        arst_n, start;
  logic [9:0]  imem_count;
  logic [31:0] run_cycles;
  logic [10:0] dump_count;
  logic        s_valid, s_ready;
  logic [31:0] s_data;
  logic        m_valid, m_ready, m_last;
  logic [63:0] m_data;
  logic        busy, done, cpu_enable;
  logic [63:0] addr_ext, addr_ext_2, rdata_ext_2;
  logic        wen_ext, ren_ext_2;
  logic [31:0] wdata_ext;

  always #5 clk = ~clk;

  ext_mem_loader #(.IMEM_WORDS(IMEM_WORDS), .DMEM_WORDS(DMEM_WORDS)) dut (
    .clk(clk), .arst_n(arst_n), .start(start), .imem_count(imem_count),
    .run_cycles(run_cycles), .dump_count(dump_count), .s_valid(s_valid),
    .s_ready(s_ready), .s_data(s_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last), .busy(busy), .done(done),
    .cpu_enable(cpu_enable), .addr_ext(addr_ext), .wen_ext(wen_ext),
    .wdata_ext(wdata_ext), .addr_ext_2(addr_ext_2), .ren_ext_2(ren_ext_2),
    .rdata_ext_2(rdata_ext_2)
  );

  logic [31:0] imem [IMEM_WORDS];
  logic [63:0] dmem [DMEM_WORDS];
  logic [31:0] prog [1024];

  // Data memory with one cycle of read latency.
  always @(posedge clk) if (ren_ext_2) rdata_ext_2 <= dmem[addr_ext_2[12:3]];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic outs_zero();
    return !(s_ready | m_valid | m_last | busy | done | cpu_enable | wen_ext | ren_ext_2 |
             (|m_data) | (|addr_ext) | (|wdata_ext) | (|addr_ext_2));
  endfunction

  // Per-transaction observations.
  int nw, addr_err, en_cnt, en_first, en_last, nr, rd_addr_err, done_cyc, ndone;
  int overlap_err, stab_err, busy_err, wcyc_err;
  logic s_ready_c1, busy_c1, timed_out, rst_ok;
  logic [63:0] last_waddr;
  logic [63:0] outq[$];
  bit lastq[$];

  task automatic run_txn(input int ic, input int rc, input int dc, input int gap, input int mrp,
                         input int hold_word, input int again_at, input int rst_at, input int budget);
    int cyc, sp, held;
    logic hs_s, prev_stall, prev_last;
    logic [63:0] prev_data;
    nw = 0; addr_err = 0; en_cnt = 0; en_first = 0; en_last = 0; nr = 0; rd_addr_err = 0;
    done_cyc = -1; ndone = 0; overlap_err = 0; stab_err = 0; busy_err = 0; wcyc_err = 0;
    s_ready_c1 = 0; busy_c1 = 0; timed_out = 0; rst_ok = 0; last_waddr = '0;
    outq.delete(); lastq.delete();
    for (int i = 0; i < IMEM_WORDS; i++) imem[i] = SENT;
    @(posedge clk); #1;
    imem_count = ic[9:0]; run_cycles = rc; dump_count = dc[10:0]; start = 1'b1;
    sp = 0; held = 0; cyc = 0; prev_stall = 0; prev_last = 0; prev_data = '0;
    s_data = prog[0];
    s_valid = ($urandom_range(0, 99) >= gap);
    m_ready = (hold_word >= 0) ? 1'b1 : ($urandom_range(0, 99) >= mrp);
    while (1) begin
      @(negedge clk);
      if (rst_at >= 0 && cyc == rst_at + 1) begin
        rst_ok = outs_zero();
        break;
      end
      if (cyc == 1) begin s_ready_c1 = s_ready; busy_c1 = busy; end
      if (wen_ext) begin
        if (addr_ext != 64'(nw) * 4) addr_err++;
        if (cyc != nw + 2) wcyc_err++;
        imem[addr_ext[10:2]] = wdata_ext;
        last_waddr = addr_ext;
        nw++;
      end
      if (cpu_enable) begin
        if (en_cnt == 0) en_first = cyc;
        en_last = cyc;
        en_cnt++;
      end
      if (ren_ext_2) begin
        nr++;
        if (addr_ext_2 != 64'(outq.size()) * 8) rd_addr_err++;
        if (m_valid) stab_err++;
      end
      if ((wen_ext && ren_ext_2) || (cpu_enable && (wen_ext || ren_ext_2))) overlap_err++;
      if (prev_stall && (!m_valid || m_data != prev_data || m_last != prev_last)) stab_err++;
      if (m_valid && !m_ready) held++;
      prev_stall = m_valid && !m_ready; prev_data = m_data; prev_last = m_last;
      if (m_valid && m_ready) begin outq.push_back(m_data); lastq.push_back(m_last); end
      if (done) begin ndone++; done_cyc = cyc; if (busy) busy_err++; end
      else if (cyc >= 1 && !busy) busy_err++;
      hs_s = s_valid && s_ready;
      if (done) break;
      if (cyc >= budget) begin timed_out = 1; break; end
      @(posedge clk); #1;
      cyc++;
      start = (cyc == again_at);
      if (cyc == 1) begin imem_count = 10'd7; run_cycles = 32'd99; dump_count = 11'd9; end
      if (hs_s) sp++;
      s_data = prog[sp % 1024];
      s_valid = ($urandom_range(0, 99) >= gap);
      if (hold_word >= 0) m_ready = !(outq.size() == hold_word && held < 5);
      else m_ready = ($urandom_range(0, 99) >= mrp);
      if (rst_at >= 0 && cyc == rst_at) arst_n = 1'b0;
    end
    start = 1'b0; s_valid = 1'b0;
    if (timed_out) begin
      @(posedge clk); #1 arst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 arst_n = 1'b1;
    end
  endtask

  task automatic check_txn(input string tag, input int ic, input int rc, input int dc, input int gap,
                           input int exp_w, input int exp_en, input int exp_words, input int exp_done);
    int eff_n, eff_d, mism, lmism;
    eff_n = (ic > IMEM_WORDS) ? IMEM_WORDS : ic;
    eff_d = (dc > DMEM_WORDS) ? DMEM_WORDS : dc;
    chk({tag, " timeout"}, 64'(timed_out), 0);
    chk({tag, " writes"}, nw, exp_w);
    chk({tag, " write_addr_seq"}, addr_err, 0);
    mism = 0;
    for (int i = 0; i < IMEM_WORDS; i++) if (imem[i] !== ((i < eff_n) ? prog[i] : SENT)) mism++;
    chk({tag, " imem_content"}, mism, 0);
    if (eff_n > 0) chk({tag, " last_waddr"}, last_waddr, 64'(eff_n - 1) * 4);
    if (gap == 0) chk({tag, " write_cycles"}, wcyc_err, 0);
    chk({tag, " enable_cycles"}, en_cnt, exp_en);
    if (rc > 0) chk({tag, " enable_contig"}, en_last - en_first + 1, rc);
    chk({tag, " reads"}, nr, eff_d);
    chk({tag, " read_addr_seq"}, rd_addr_err, 0);
    chk({tag, " words_out"}, outq.size(), exp_words);
    mism = 0; lmism = 0;
    for (int i = 0; i < outq.size(); i++) begin
      if (outq[i] !== dmem[i]) mism++;
      if (lastq[i] != (i == eff_d - 1)) lmism++;
    end
    chk({tag, " dump_data"}, mism, 0);
    chk({tag, " m_last"}, lmism, 0);
    chk({tag, " done_pulses"}, ndone, 1);
    chk({tag, " busy"}, busy_err, 0);
    chk({tag, " busy_c1"}, 64'(busy_c1), 1);
    chk({tag, " s_ready_c1"}, 64'(s_ready_c1), 64'(eff_n > 0));
    chk({tag, " port_overlap"}, overlap_err, 0);
    chk({tag, " out_stable"}, stab_err, 0);
    if (exp_done >= 0) chk({tag, " done_cycle"}, done_cyc, exp_done);
  endtask

  typedef struct {
    int ic, rc, dc, gap, mrp, hold, again;
    int exp_w, exp_en, exp_words, exp_done;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int ic, rc, dc;
    vecs[0] = '{3,    20, 4,    0,  0,  -1, -1,  3,   20, 4,    37};
    vecs[1] = '{3,    0,  4,    0,  0,  -1, -1,  3,   0,  4,    18};
    vecs[2] = '{3,    20, 4,    0,  0,  1,  -1,  3,   20, 4,    42};
    vecs[3] = '{0,    5,  2,    0,  0,  -1, -1,  0,   5,  2,    12};
    vecs[4] = '{2,    3,  0,    0,  0,  -1, -1,  2,   3,  0,    7};
    vecs[5] = '{0,    0,  0,    0,  0,  -1, -1,  0,   0,  0,    2};
    vecs[6] = '{1023, 1,  1,    0,  0,  -1, 100, 512, 1,  1,    518};
    vecs[7] = '{5,    2,  2047, 0,  0,  -1, -1,  5,   2,  1024, 3081};
    vecs[8] = '{10,   7,  5,    30, 30, -1, 4,   10,  7,  5,    -1};

    prog[0] = 32'h0050_0093; prog[1] = 32'h00A0_0113; prog[2] = 32'h0020_81B3;
    for (int i = 3; i < 1024; i++) prog[i] = $urandom;
    for (int i = 0; i < DMEM_WORDS; i++) dmem[i] = {$urandom, $urandom};
    dmem[0] = 64'h11; dmem[1] = 64'h22; dmem[2] = 64'h33; dmem[3] = 64'h44;

    arst_n = 1'b0; start = 1'b0; imem_count = '0; run_cycles = '0; dump_count = '0;
    s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs_zero", 64'(outs_zero()), 1);
    #1 arst_n = 1'b1;
    @(negedge clk);
    chk("idle_outputs_zero", 64'(outs_zero()), 1);

    for (int v = 0; v < 9; v++) begin
      run_txn(vecs[v].ic, vecs[v].rc, vecs[v].dc, vecs[v].gap, vecs[v].mrp,
              vecs[v].hold, vecs[v].again, -1, 4000);
      check_txn($sformatf("vec%0d", v), vecs[v].ic, vecs[v].rc, vecs[v].dc, vecs[v].gap,
                vecs[v].exp_w, vecs[v].exp_en, vecs[v].exp_words, vecs[v].exp_done);
    end

    // Reset in the middle of a 5-word load, then a clean full load.
    run_txn(5, 3, 2, 0, 0, -1, -1, 3, 100);
    chk("mid_load_reset_zero", 64'(rst_ok), 1);
    arst_n = 1'b1;
    run_txn(5, 3, 2, 0, 0, -1, -1, -1, 200);
    check_txn("after_reset", 5, 3, 2, 0, 5, 3, 2, 16);

    // Randomized transactions against the behavioural model.
    for (int t = 0; t < 12; t++) begin
      int eff_n, eff_d, gap, mrp;
      for (int i = 0; i < 1024; i++) prog[i] = $urandom;
      for (int i = 0; i < DMEM_WORDS; i++) dmem[i] = {$urandom, $urandom};
      ic = ($urandom_range(0, 9) == 0) ? int'($urandom_range(500, 1023)) : int'($urandom_range(0, 20));
      rc = $urandom_range(0, 30);
      dc = $urandom_range(0, 12);
      gap = $urandom_range(0, 40);
      mrp = $urandom_range(0, 40);
      eff_n = (ic > IMEM_WORDS) ? IMEM_WORDS : ic;
      eff_d = (dc > DMEM_WORDS) ? DMEM_WORDS : dc;
      run_txn(ic, rc, dc, gap, mrp, -1, $urandom_range(2, 10), -1,
              20 * (eff_n + rc + 4 * eff_d) + 100);
      check_txn($sformatf("rand%0d", t), ic, rc, dc, gap, eff_n, rc, eff_d, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
